clk_div_ctrl: RTL and testbench

- Controller and arbiter for a shared programmable clock divider.
- Two requesters each ask for a divide ratio. A round-robin arbiter accepts one request at a time.
- The accepted ratio is applied only at a period boundary, so ClkOut never has a runt pulse.
- Sits between the system control logic and the divided-clock/tick consumers (D2/D4-style dividers, generalised to any ratio).

---
 rtl/clk_div_ctrl.sv | 114 +++++++++++
 tb/tb_clk_div_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Round-robin arbitrated controller for a programmable clock divider; new ratios take effect only at period boundaries.
// Optional build macro CLKDIV_STATS_EN adds the ChgCnt applied-change counter output.
module clk_div_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic [1:0]       Req,
   input  logic [CNT_W-1:0] Div0,
   input  logic [CNT_W-1:0] Div1,
   output logic [1:0]       Ack,
   output logic [1:0]       Err,
   output logic             Busy,
   output logic [CNT_W-1:0] Count,
   output logic             Tick,
   output logic             ClkOut
`ifdef CLKDIV_STATS_EN
   ,
   output logic [7:0]       ChgCnt
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   state_t           state_reg;
   logic [CNT_W-1:0] active_reg;
   logic [CNT_W-1:0] pending_reg;
   logic             last_reg;

   logic [1:0]       elig;
   logic             gnt_valid;
   logic             gnt_idx;
   logic [CNT_W-1:0] gnt_div;
   logic             gnt_ok;
   logic [1:0]       ack_next;
   logic [1:0]       err_next;
   logic             last_cnt;
   logic             apply;
   logic [CNT_W-1:0] active_next;
   logic             run_next;
   logic [CNT_W-1:0] count_next;

   always_comb begin
      // A requester whose Ack/Err is showing this cycle is still holding Req; skip it.
      elig      = Req & ~Ack & ~Err;
      gnt_valid = ~Busy & (|elig);
      gnt_idx   = (elig == 2'b11) ? ~last_reg : elig[1];
      gnt_div   = gnt_idx ? Div1 : Div0;
      gnt_ok    = (gnt_div >= TWO);
      ack_next  = 2'b00;
      err_next  = 2'b00;
      if (gnt_valid) begin
         if (gnt_ok) ack_next = gnt_idx ? 2'b10 : 2'b01;
         else        err_next = gnt_idx ? 2'b10 : 2'b01;
      end

      last_cnt    = (state_reg == RUN) && (Count == active_reg - ONE);
      apply       = Busy && ((state_reg == IDLE) || last_cnt);
      active_next = apply ? pending_reg : active_reg;
      run_next    = En && (active_next >= TWO);

      count_next = '0;
      if (run_next && (state_reg == RUN) && !last_cnt)
         count_next = Count + ONE;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg   <= IDLE;
         active_reg  <= '0;
         pending_reg <= '0;
         last_reg    <= 1'b1;
         Ack         <= 2'b00;
         Err         <= 2'b00;
         Busy        <= 1'b0;
         Count       <= '0;
         Tick        <= 1'b0;
         ClkOut      <= 1'b0;
      end else begin
         Ack <= ack_next;
         Err <= err_next;
         if (gnt_valid) begin
            last_reg <= gnt_idx;
            if (gnt_ok) begin
               pending_reg <= gnt_div;
               Busy        <= 1'b1;
            end
         end
         // Grants only happen with Busy low and applies only with Busy high, so these never collide.
         if (apply) begin
            active_reg <= pending_reg;
            Busy       <= 1'b0;
         end
         state_reg <= run_next ? RUN : IDLE;
         Count     <= count_next;
         Tick      <= run_next && (count_next == active_next - ONE);
         ClkOut    <= run_next && (count_next < (active_next >> 1));
      end
   end

`ifdef CLKDIV_STATS_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         ChgCnt <= 8'd0;
      else if (apply && (ChgCnt != 8'hFF))
         ChgCnt <= ChgCnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; covers ChgCnt when built with CLKDIV_STATS_EN.
module tb_clk_div_ctrl;

   logic       Clk;
   logic       Rst;
   logic       En;
   logic [1:0] Req;
   logic [7:0] Div0;
   logic [7:0] Div1;
   logic [1:0] Ack;
   logic [1:0] Err;
   logic       Busy;
   logic [7:0] Count;
   logic       Tick;
   logic       ClkOut;
`ifdef CLKDIV_STATS_EN
   logic [7:0] ChgCnt;
`endif

   int checks   = 0;
   int failures = 0;

   clk_div_ctrl #(.CNT_W(8)) dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .En     (En),
      .Req    (Req),
      .Div0   (Div0),
      .Div1   (Div1),
      .Ack    (Ack),
      .Err    (Err),
      .Busy   (Busy),
      .Count  (Count),
      .Tick   (Tick),
      .ClkOut (ClkOut)
`ifdef CLKDIV_STATS_EN
      ,
      .ChgCnt (ChgCnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_cnt(input logic [7:0] v, input int lim, output bit ok);
      int n;
      n = 0;
      while (Count !== v && n < lim) begin
         cyc();
         n++;
      end
      ok = (Count === v);
   endtask

   task automatic wait_not_busy(input int lim, output bit ok);
      int n;
      n = 0;
      while (Busy !== 1'b0 && n < lim) begin
         cyc();
         n++;
      end
      ok = (Busy === 1'b0);
   endtask

   task automatic test_reset();
      Rst = 1'b0; En = 1'b0; Req = 2'b00; Div0 = 8'd0; Div1 = 8'd0;
      #1 Rst = 1'b1;
      #1;
      checks++;
      if ({Ack, Err, Busy, Count, Tick, ClkOut} !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", {Ack, Err, Busy, Count, Tick, ClkOut});
      end
      @(posedge Clk);
      #1 Rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      En = 1'b1; Req = 2'b01; Div0 = 8'd4;
      cyc();
      checks++;
      if (Ack !== 2'b01 || Busy !== 1'b1 || Err !== 2'b00) begin
         failures++;
         $display("FAIL basic_ack got ack=%b busy=%b err=%b want ack=01 busy=1 err=00", Ack, Busy, Err);
      end
      Req = 2'b00;
      for (int i = 0; i < 8; i++) begin
         cyc();
         checks++;
         if (Count !== 8'(i % 4) || ClkOut !== ((i % 4) < 2) || Tick !== ((i % 4) == 3) || Ack !== 2'b00) begin
            failures++;
            $display("FAIL basic_period i=%0d got cnt=%0d clk=%b tick=%b ack=%b want cnt=%0d clk=%b tick=%b ack=00",
                     i, Count, ClkOut, Tick, Ack, i % 4, (i % 4) < 2, (i % 4) == 3);
         end
      end
      $display("test_basic done");
   endtask

   task automatic test_switch();
      bit ok;
      wait_cnt(8'd1, 10, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL switch_sync got cnt=%0d want 1", Count);
      end
      Req = 2'b10; Div1 = 8'd6;
      cyc();
      checks++;
      if (Ack !== 2'b10 || Busy !== 1'b1 || Count !== 8'd2) begin
         failures++;
         $display("FAIL switch_ack got ack=%b busy=%b cnt=%0d want ack=10 busy=1 cnt=2", Ack, Busy, Count);
      end
      Req = 2'b00;
      cyc();
      checks++;
      if (Count !== 8'd3 || Busy !== 1'b1 || Tick !== 1'b1 || Ack !== 2'b00) begin
         failures++;
         $display("FAIL switch_wrap got cnt=%0d busy=%b tick=%b ack=%b want cnt=3 busy=1 tick=1 ack=00",
                  Count, Busy, Tick, Ack);
      end
      cyc();
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (Count !== 8'(i % 6) || ClkOut !== ((i % 6) < 3) || Tick !== ((i % 6) == 5) || Busy !== 1'b0) begin
            failures++;
            $display("FAIL switch_period i=%0d got cnt=%0d clk=%b tick=%b busy=%b want cnt=%0d clk=%b tick=%b busy=0",
                     i, Count, ClkOut, Tick, Busy, i % 6, (i % 6) < 3, (i % 6) == 5);
         end
         cyc();
      end
      $display("test_switch done");
   endtask

   task automatic test_reject();
      Req = 2'b01; Div0 = 8'd1;
      cyc();
      checks++;
      if (Err !== 2'b01 || Ack !== 2'b00 || Busy !== 1'b0 || Count !== 8'd1) begin
         failures++;
         $display("FAIL reject_err got err=%b ack=%b busy=%b cnt=%0d want err=01 ack=00 busy=0 cnt=1",
                  Err, Ack, Busy, Count);
      end
      cyc();
      checks++;
      if (Err !== 2'b00 || Ack !== 2'b00 || Busy !== 1'b0) begin
         failures++;
         $display("FAIL reject_nogrant got err=%b ack=%b busy=%b want err=00 ack=00 busy=0", Err, Ack, Busy);
      end
      Req = 2'b00;
      cyc(); cyc(); cyc();
      checks++;
      if (Count !== 8'd5 || Tick !== 1'b1) begin
         failures++;
         $display("FAIL reject_ratio got cnt=%0d tick=%b want cnt=5 tick=1", Count, Tick);
      end
      cyc();
      checks++;
      if (Count !== 8'd0 || ClkOut !== 1'b1) begin
         failures++;
         $display("FAIL reject_wrap got cnt=%0d clk=%b want cnt=0 clk=1", Count, ClkOut);
      end
      $display("test_reject done");
   endtask

   task automatic test_rr();
      bit ok;
      logic [7:0] exp_cnt [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd2, 8'd0};
      logic       exp_clk [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic       exp_tick[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       exp_busy[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      Req = 2'b11; Div0 = 8'd3; Div1 = 8'd5;
      cyc();
      checks++;
      if (Ack !== 2'b10 || Busy !== 1'b1) begin
         failures++;
         $display("FAIL rr_first got ack=%b busy=%b want ack=10 busy=1", Ack, Busy);
      end
      Req = 2'b01;
      wait_not_busy(10, ok);
      checks++;
      if (!ok || Ack !== 2'b00) begin
         failures++;
         $display("FAIL rr_apply_wait got busy=%b ack=%b want busy=0 ack=00", Busy, Ack);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (Count !== exp_cnt[i] || ClkOut !== exp_clk[i] || Tick !== exp_tick[i] || Busy !== exp_busy[i]) begin
            failures++;
            $display("FAIL rr_seq i=%0d got cnt=%0d clk=%b tick=%b busy=%b want cnt=%0d clk=%b tick=%b busy=%b",
                     i, Count, ClkOut, Tick, Busy, exp_cnt[i], exp_clk[i], exp_tick[i], exp_busy[i]);
         end
         if (i == 1) begin
            checks++;
            if (Ack !== 2'b01) begin
               failures++;
               $display("FAIL rr_second got ack=%b want 01", Ack);
            end
            Req = 2'b00;
         end
         cyc();
      end
`ifdef CLKDIV_STATS_EN
      checks++;
      if (ChgCnt !== 8'd4) begin
         failures++;
         $display("FAIL stats_after_rr got=%0d want=4", ChgCnt);
      end
`endif
      $display("test_rr done");
   endtask

   task automatic test_en();
      bit ok;
      wait_cnt(8'd1, 10, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL en_sync got cnt=%0d want 1", Count);
      end
      En = 1'b0;
      cyc();
      checks++;
      if (Count !== 8'd0 || ClkOut !== 1'b0 || Tick !== 1'b0) begin
         failures++;
         $display("FAIL en_off got cnt=%0d clk=%b tick=%b want 0 0 0", Count, ClkOut, Tick);
      end
      cyc();
      checks++;
      if (Count !== 8'd0 || ClkOut !== 1'b0) begin
         failures++;
         $display("FAIL en_off_hold got cnt=%0d clk=%b want 0 0", Count, ClkOut);
      end
      En = 1'b1;
      cyc();
      checks++;
      if (Count !== 8'd0 || ClkOut !== 1'b1) begin
         failures++;
         $display("FAIL en_restart got cnt=%0d clk=%b want cnt=0 clk=1", Count, ClkOut);
      end
      cyc();
      cyc();
      checks++;
      if (Count !== 8'd2 || Tick !== 1'b1 || ClkOut !== 1'b0) begin
         failures++;
         $display("FAIL en_ratio got cnt=%0d tick=%b clk=%b want cnt=2 tick=1 clk=0", Count, Tick, ClkOut);
      end
      $display("test_en done");
   endtask

   task automatic test_rst_mid();
      bit ok;
      wait_cnt(8'd2, 10, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rst_sync got cnt=%0d want 2", Count);
      end
      #2 Rst = 1'b1;
      #1;
      checks++;
      if ({Ack, Err, Busy, Count, Tick, ClkOut} !== 14'd0) begin
         failures++;
         $display("FAIL rst_async got=%h want=0", {Ack, Err, Busy, Count, Tick, ClkOut});
      end
      @(posedge Clk);
      #1 Rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++;
         if (Count !== 8'd0 || ClkOut !== 1'b0 || Tick !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle i=%0d got cnt=%0d clk=%b tick=%b want 0 0 0", i, Count, ClkOut, Tick);
         end
      end
`ifdef CLKDIV_STATS_EN
      checks++;
      if (ChgCnt !== 8'd0) begin
         failures++;
         $display("FAIL stats_reset got=%0d want=0", ChgCnt);
      end
`endif
      Req = 2'b11; Div0 = 8'd2; Div1 = 8'd7;
      cyc();
      checks++;
      if (Ack !== 2'b01) begin
         failures++;
         $display("FAIL rst_rr_ptr got ack=%b want 01", Ack);
      end
      Req = 2'b00;
      cyc();
      checks++;
      if (Count !== 8'd0 || ClkOut !== 1'b1) begin
         failures++;
         $display("FAIL rst_newrun got cnt=%0d clk=%b want cnt=0 clk=1", Count, ClkOut);
      end
      cyc();
      checks++;
      if (Count !== 8'd1 || ClkOut !== 1'b0 || Tick !== 1'b1) begin
         failures++;
         $display("FAIL rst_div2 got cnt=%0d clk=%b tick=%b want cnt=1 clk=0 tick=1", Count, ClkOut, Tick);
      end
      $display("test_rst_mid done");
   endtask

   task automatic test_max();
      bit ok;
      Req = 2'b01; Div0 = 8'd255;
      cyc();
      checks++;
      if (Ack !== 2'b01) begin
         failures++;
         $display("FAIL max_ack got ack=%b want 01", Ack);
      end
      Req = 2'b00;
      wait_not_busy(10, ok);
      checks++;
      if (!ok || Count !== 8'd0 || ClkOut !== 1'b1) begin
         failures++;
         $display("FAIL max_apply got busy=%b cnt=%0d clk=%b want busy=0 cnt=0 clk=1", Busy, Count, ClkOut);
      end
      for (int i = 1; i < 255; i++) begin
         cyc();
         checks++;
         if (Count !== 8'(i) || ClkOut !== (i < 127) || Tick !== (i == 254)) begin
            failures++;
            $display("FAIL max_period got cnt=%0d clk=%b tick=%b want cnt=%0d clk=%b tick=%b",
                     Count, ClkOut, Tick, i, i < 127, i == 254);
         end
      end
      cyc();
      checks++;
      if (Count !== 8'd0 || Tick !== 1'b0) begin
         failures++;
         $display("FAIL max_wrap got cnt=%0d tick=%b want cnt=0 tick=0", Count, Tick);
      end
`ifdef CLKDIV_STATS_EN
      checks++;
      if (ChgCnt !== 8'd2) begin
         failures++;
         $display("FAIL stats_after_max got=%0d want=2", ChgCnt);
      end
`endif
      $display("test_max done");
   endtask

`ifdef CLKDIV_STATS_EN
   task automatic test_stats_sat();
      bit ok;
      bit timed_out;
      timed_out = 1'b0;
      for (int k = 0; k < 300 && !timed_out; k++) begin
         Req = 2'b01; Div0 = (k % 2 == 0) ? 8'd2 : 8'd3;
         cyc();
         if (Ack !== 2'b01) timed_out = 1'b1;
         Req = 2'b00;
         wait_not_busy(300, ok);
         if (!ok) timed_out = 1'b1;
      end
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL stats_loop got ack=%b busy=%b want handshake completion", Ack, Busy);
      end
      checks++;
      if (ChgCnt !== 8'd255) begin
         failures++;
         $display("FAIL stats_saturate got=%0d want=255", ChgCnt);
      end
      $display("test_stats_sat done");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_switch();
      test_reject();
      test_rr();
      test_en();
      test_rst_mid();
      test_max();
`ifdef CLKDIV_STATS_EN
      test_stats_sat();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
